// File: rtl/arith_pkg.sv
// Shared arithmetic constants and elaboration-time helpers for the adder blocks.
package arith_pkg;

    localparam int SUM4_DEFAULT_WIDTH = 4;
    localparam int SUM4_MIN_WIDTH     = 1;
    localparam int SUM4_MAX_WIDTH     = 32;

    function automatic bit width_is_legal(input int width);
        return (width >= SUM4_MIN_WIDTH) && (width <= SUM4_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; the ripple chain in sum4 is built from these.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/sum4.sv
// Registered WIDTH-bit ripple-carry adder: full-adder chain feeding an output
// register stage with one cycle of latency and an asynchronous active-high reset.
module sum4
    import arith_pkg::*;
#(
    parameter int WIDTH = SUM4_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             out_valid
);

    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("sum4: WIDTH=%0d outside legal range 1..32", WIDTH);
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .x  (a[i]),
            .y  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result registers only load on a qualified cycle, so idle-cycle
            // operands (even X) never reach the outputs.
            if (in_valid) begin
                sum   <= s;
                carry <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sum4.sv
// Scoreboard bench for sum4 at WIDTH=4 and WIDTH=8 against plain-arithmetic expectations.
module tb_sum4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] a4 = '0, b4 = '0, sum4_o;
    logic       cin4 = 1'b0, iv4 = 1'b0, carry4, ov4;
    logic [7:0] a8 = '0, b8 = '0, sum8_o;
    logic       cin8 = 1'b0, iv8 = 1'b0, carry8, ov8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] q4[$];
    logic [8:0] q8[$];
    logic [4:0] last4 = '0;
    logic [8:0] last8 = '0;

    always #5 clk = ~clk;

    sum4 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .sum(sum4_o), .carry(carry4),
        .a(a4), .b(b4), .cin(cin4), .in_valid(iv4), .out_valid(ov4)
    );

    sum4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .sum(sum8_o), .carry(carry8),
        .a(a8), .b(b8), .cin(cin8), .in_valid(iv8), .out_valid(ov8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive on the falling edge; the rising edge that follows captures.
    task automatic drive4(input int a, input int b, input int c, input bit v);
        @(negedge clk);
        a4 = a[3:0]; b4 = b[3:0]; cin4 = c[0]; iv4 = v;
        if (v) q4.push_back(5'(a[3:0] + b[3:0] + c[0]));
    endtask

    task automatic drive8(input int a, input int b, input int c, input bit v);
        @(negedge clk);
        a8 = a[7:0]; b8 = b[7:0]; cin8 = c[0]; iv8 = v;
        if (v) q8.push_back(9'(a[7:0] + b[7:0] + c[0]));
    endtask

    // Monitors: an output is due exactly when the scoreboard holds one;
    // otherwise the previous result must be held.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("ov4", 32'(ov4), 32'(q4.size() != 0));
            if (q4.size() != 0) last4 = q4.pop_front();
            check("res4", 32'({carry4, sum4_o}), 32'(last4));
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("ov8", 32'(ov8), 32'(q8.size() != 0));
            if (q8.size() != 0) last8 = q8.pop_front();
            check("res8", 32'({carry8, sum8_o}), 32'(last8));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int va[5]  = '{4'b0001, 4'b0101, 4'b1101, 4'b0101, 4'b1101};
        int vb[5]  = '{4'b1101, 4'b0101, 4'b1101, 4'b1100, 4'b1111};
        int vc[5]  = '{0, 0, 1, 0, 1};
        int exp5[5] = '{5'b0_1110, 5'b0_1010, 5'b1_1011, 5'b1_0001, 5'b1_1101};

        // Power-on reset.
        #2;
        check("por_sum4", 32'(sum4_o), 0);
        check("por_carry4", 32'(carry4), 0);
        check("por_ov4", 32'(ov4), 0);
        check("por_ov8", 32'(ov8), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, back-to-back; the table's expected column is also
        // cross-checked against the plain sum.
        for (int i = 0; i < 5; i++) begin
            check("table", 32'(exp5[i]), 32'(va[i] + vb[i] + vc[i]));
            drive4(va[i], vb[i], vc[i], 1'b1);
        end

        // Extremes.
        drive4(15, 15, 1, 1'b1);
        drive4(0, 0, 0, 1'b1);
        drive4(15, 0, 1, 1'b1);

        // Hold: 1110/0 registered, then idle cycles with all-ones operands.
        drive4(1, 13, 0, 1'b1);
        for (int i = 0; i < 3; i++) drive4(15, 15, 0, 1'b0);

        // Reset mid-operation with a nonzero result registered and one in flight.
        drive4(13, 13, 1, 1'b1);
        drive4(5, 12, 0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_sum4", 32'(sum4_o), 0);
        check("rst_carry4", 32'(carry4), 0);
        check("rst_ov4", 32'(ov4), 0);
        q4.delete();
        q8.delete();
        last4 = '0;
        last8 = '0;
        iv4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_sum4", 32'(sum4_o), 0);
        check("rst_hold_ov4", 32'(ov4), 0);
        @(negedge clk);
        rst = 1'b0;
        drive4(0, 0, 0, 1'b0);

        // Exhaustive WIDTH=4.
        for (int i = 0; i < 512; i++) drive4(i & 15, (i >> 4) & 15, (i >> 8) & 1, 1'b1);
        drive4(0, 0, 0, 1'b0);

        // Random WIDTH=8 with occasional idle cycles carrying random operands.
        for (int i = 0; i < 1000; i++) begin
            drive8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 7) == 0)
                drive8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 1)), 1'b0);
        end
        drive8(255, 255, 1, 1'b1);
        drive8(0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);

        check("drain4", 32'(q4.size()), 0);
        check("drain8", 32'(q8.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum4.md
Name: sum4

Overview:
- Registered WIDTH-bit (default 4) ripple-carry adder with carry-in and carry-out, for datapath and arithmetic exercises.
- Combinational core is a chain of full-adder cells.
- Result and carry-out are captured in output registers: one clock of latency, deterministic reset state.
- Operands are unsigned; carry-out is the unsigned overflow bit.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sum  output  WIDTH  registered sum bits (a + b + cin) modulo 2^WIDTH.
- carry  output  1  registered carry-out, bit WIDTH of a + b + cin.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- in_valid  input  1  qualifies a/b/cin for capture this cycle.
- out_valid  output  1  sum/carry hold a result captured on the previous edge.

Positional instantiation order: clk, rst, sum, carry, a, b, cin, in_valid, out_valid.

Behaviour:
- Reset (asynchronous, active-high):
  - rst=1 immediately forces sum=0, carry=0, out_valid=0, independent of clk.
  - All three hold while rst=1.
  - The first capture is the first rising clk edge after rst deasserts.
- Combinational core:
  - c[0]=cin.
  - For i in 0..WIDTH-1: s[i]=a[i]^b[i]^c[i]; c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])).
  - The full result is {c[WIDTH], s} = a + b + cin, computed exactly at WIDTH+1 bits.
- Capture:
  - On each rising clk edge with rst=0 and in_valid=1: sum<=s, carry<=c[WIDTH], out_valid<=1.
  - On each rising clk edge with rst=0 and in_valid=0: sum and carry hold their previous values, out_valid<=0.
- Latency and throughput:
  - Latency is exactly 1 cycle from the edge sampling in_valid=1 to the result visible on sum/carry.
  - Throughput is one addition per cycle; back-to-back in_valid is fully supported.
- No backpressure. Results are not stalled; downstream must consume on out_valid.
- Boundaries:
  - Maximum operands (all-ones + all-ones + cin=1) give sum=all-ones, carry=1.
  - Zero operands with cin=0 give sum=0, carry=0.
  - Wrap-around is modulo 2^WIDTH with carry reporting the overflow.
  - Overflow is not signed; no signed-overflow flag is provided.
- Reset mid-operation: any result in flight is discarded; out_valid=0 until the next valid capture after release.
- Inputs changing between edges have no effect on outputs; only sampled values matter.
- No X propagation from a/b/cin into outputs when in_valid=0.

Decomposition:
- Shared package arith_pkg:
  - constant SUM4_DEFAULT_WIDTH=4.
  - Width-check helper or constant used by elaboration-time assertion (1<=WIDTH<=32).
- Sub-module full_adder: inputs x, y, ci; outputs s, co.
  - Instantiated WIDTH times in a generate loop forming the ripple chain.
- Top sum4 contains the generate chain, the output register stage with asynchronous reset, and the parameter assertion.

Test Plan:
- Reset: assert rst mid-cycle with prior nonzero result -> sum=0000, carry=0, out_valid=0 immediately, without waiting for clk; hold for 2 cycles, release.
- Directed vectors, WIDTH=4, in_valid=1, each checked 1 cycle later with out_valid=1:

  | a | b | cin | sum | carry |
  |------|------|-----|------|-------|
  | 0001 | 1101 | 0 | 1110 | 0 |
  | 0101 | 0101 | 0 | 1010 | 0 |
  | 1101 | 1101 | 1 | 1011 | 1 |
  | 0101 | 1100 | 0 | 0001 | 1 |
  | 1101 | 1111 | 1 | 1101 | 1 |

- Extremes: 1111+1111+1 -> sum=1111, carry=1; 0000+0000+0 -> sum=0000, carry=0; 1111+0000+1 -> sum=0000, carry=1.
- Hold: result 1110/0 registered, then in_valid=0 with a=1111, b=1111 for 3 cycles -> sum stays 1110, carry 0, out_valid=0.
- Back-to-back: in_valid=1 on 5 consecutive cycles with the vectors above -> results appear in the same order on the following 5 consecutive cycles, out_valid continuously 1.
- Exhaustive/random: all 512 combinations of a, b, cin for WIDTH=4, plus 1000 random vectors at WIDTH=8 -> {carry,sum} equals a+b+cin one cycle later.
